// File: rtl/sram_pkg.sv
// Shared constants and port-select encoding for the SRAM arbiter and its users.
package sram_pkg;

  localparam int unsigned SRAM_ADDR_W = 16;
  localparam int unsigned SRAM_DATA_W = 32;
  localparam int unsigned SRAM_LANES  = SRAM_DATA_W / 8;
  localparam int unsigned SRAM_WAIT_W = 4;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_I,
    SEL_D
  } port_sel_e;

endpackage

// File: rtl/sram_arb_grant.sv
// Combinational priority decision: data beats fetch unless the starvation guard forces fetch.
// The guard is present only when SRAM_ARB_STARVE_GUARD_EN is defined.
module sram_arb_grant
  import sram_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic                   i_req,
  input  logic                   d_req,
`ifdef SRAM_ARB_STARVE_GUARD_EN
  input  logic [SRAM_WAIT_W-1:0] wait_cnt,
`endif
  output logic [1:0]             port_sel
);

  logic force_i;

`ifdef SRAM_ARB_STARVE_GUARD_EN
  assign force_i = i_req & (wait_cnt == SRAM_WAIT_W'(MAX_WAIT));
`else
  assign force_i = 1'b0;
`endif

  always_comb begin
    port_sel = SEL_NONE;
    if (d_req && !force_i) begin
      port_sel = SEL_D;
    end else if (i_req) begin
      port_sel = SEL_I;
    end
  end

  // The wait counter is 4 bits wide, so larger limits could never be reached.
  if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : gen_max_wait_check
    $error("MAX_WAIT must be in 1..15");
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one single-ported SRAM between instruction fetch and load/store with one access per cycle.
// Define SRAM_ARB_STARVE_GUARD_EN to bound how long fetch can be starved by data traffic.
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_W   = SRAM_ADDR_W,
  parameter int unsigned DATA_W   = SRAM_DATA_W,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_W-1:0]     i_addr,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  output logic [DATA_W-1:0]     i_rdata,
  input  logic                  d_req,
  input  logic [DATA_W/8-1:0]   d_we,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  d_err,
  output logic [DATA_W/8-1:0]   sram_w_en,
  output logic [ADDR_W-1:0]     sram_addr,
  output logic [DATA_W-1:0]     sram_wdata,
  input  logic [DATA_W-1:0]     sram_rdata
);

  logic              i_req_m;
  logic              d_req_m;
  logic [1:0]        sel_raw;
  port_sel_e         sel;
  logic              d_err_now;
  logic [ADDR_W-1:0] addr_q;

  // Masking with rst keeps a write from landing in the cycle reset rises.
  assign i_req_m = i_req & ~rst;
  assign d_req_m = d_req & ~rst;

`ifdef SRAM_ARB_STARVE_GUARD_EN
  logic [SRAM_WAIT_W-1:0] wait_cnt_q;
  logic [SRAM_WAIT_W-1:0] wait_cnt_d;

  always_comb begin
    wait_cnt_d = '0;
    if (i_req_m && !i_gnt) begin
      wait_cnt_d = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`endif

  sram_arb_grant #(
    .MAX_WAIT (MAX_WAIT)
  ) u_grant (
    .i_req    (i_req_m),
    .d_req    (d_req_m),
`ifdef SRAM_ARB_STARVE_GUARD_EN
    .wait_cnt (wait_cnt_q),
`endif
    .port_sel (sel_raw)
  );

  assign sel       = port_sel_e'(sel_raw);
  assign i_gnt     = (sel == SEL_I);
  assign d_gnt     = (sel == SEL_D);
  assign d_err_now = d_gnt & (d_addr[1:0] != 2'b00);

  assign sram_wdata = d_wdata;

  always_comb begin
    sram_addr = addr_q;
    sram_w_en = '0;
    unique case (sel)
      SEL_D: begin
        sram_addr = d_addr;
        sram_w_en = d_err_now ? '0 : d_we;
      end
      SEL_I:   sram_addr = i_addr;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      d_err    <= 1'b0;
      i_rdata  <= '0;
      d_rdata  <= '0;
    end else begin
      addr_q   <= sram_addr;
      i_rvalid <= i_gnt;
      d_rvalid <= d_gnt;
      d_err    <= d_err_now;
      if (i_gnt) begin
        i_rdata <= sram_rdata;
      end
      if (d_gnt) begin
        d_rdata <= d_err_now ? '0 : sram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized scoreboard bench for sram_arbiter with a byte-array SRAM model and a word-level reference.
// Honours SRAM_ARB_STARVE_GUARD_EN when it is defined for the build.
module tb_sram_arbiter;
  import sram_pkg::*;

  localparam int unsigned MAX_WAIT = 4;
`ifdef SRAM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req, i_gnt, i_rvalid;
  logic [15:0] i_addr;
  logic [31:0] i_rdata;
  logic        d_req, d_gnt, d_rvalid, d_err;
  logic [3:0]  d_we;
  logic [15:0] d_addr;
  logic [31:0] d_wdata, d_rdata;
  logic [3:0]  sram_w_en;
  logic [15:0] sram_addr;
  logic [31:0] sram_wdata, sram_rdata;

  always #5 clk = ~clk;

  sram_arbiter #(
    .ADDR_W   (16),
    .DATA_W   (32),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_gnt      (i_gnt),
    .i_rvalid   (i_rvalid),
    .i_rdata    (i_rdata),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_gnt      (d_gnt),
    .d_rvalid   (d_rvalid),
    .d_rdata    (d_rdata),
    .d_err      (d_err),
    .sram_w_en  (sram_w_en),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  // SRAM macro model: combinational read, byte-enabled write at the clock edge.
  logic [7:0]  mem     [65536];
  logic [7:0]  ref_mem [65536];
  logic        init_en = 1'b1;
  logic        poke_en = 1'b0;
  logic [15:0] poke_addr = '0;
  logic [31:0] poke_word = '0;

  function automatic logic [7:0] init_byte(input logic [15:0] a);
    return a[7:0] ^ (a[15:8] * 8'd29) ^ 8'h5A;
  endfunction

  wire [15:0] ra1 = sram_addr + 16'd1;
  wire [15:0] ra2 = sram_addr + 16'd2;
  wire [15:0] ra3 = sram_addr + 16'd3;
  assign sram_rdata = {mem[ra3], mem[ra2], mem[ra1], mem[sram_addr]};

  always @(posedge clk) begin
    if (init_en) begin
      for (int a = 0; a < 65536; a++) mem[a] <= init_byte(16'(a));
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (sram_w_en[k]) mem[16'(sram_addr + 16'(k))] <= sram_wdata[8*k +: 8];
        if (poke_en) mem[16'(poke_addr + 16'(k))] <= poke_word[8*k +: 8];
      end
    end
  end

  typedef struct packed {
    logic        wr;
    logic        err;
    logic [31:0] data;
  } d_exp_t;

  d_exp_t      dq[$];
  logic [31:0] iq[$];
  int          total = 0;
  int          bad = 0;
  int unsigned ref_wait = 0;
  logic [15:0] last_addr = '0;
  logic        last_pi = 1'b0;
  logic        last_pd = 1'b0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] ref_word(input logic [15:0] a);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = ref_mem[16'(a + 16'(k))];
    return w;
  endfunction

  function automatic logic [15:0] rand_addr();
    logic [15:0] a;
    int unsigned r;
    a = {14'($urandom_range(0, 31)), 2'b00};
    r = $urandom_range(0, 9);
    if (r == 0) a = 16'hFFFC;
    if (r <= 1) a[1:0] = 2'($urandom_range(1, 3));
    return a;
  endfunction

  // Monitor: every response pulse must match the oldest expectation for that port.
  always @(negedge clk) begin
    if (!rst) begin
      if (i_rvalid) begin
        if (iq.size() == 0) check("i_rvalid_unexpected", 32'(i_rvalid), 32'd0);
        else check("i_rdata", i_rdata, iq.pop_front());
      end
      if (d_rvalid) begin
        if (dq.size() == 0) check("d_rvalid_unexpected", 32'(d_rvalid), 32'd0);
        else begin
          d_exp_t e;
          e = dq.pop_front();
          check("d_err", 32'(d_err), 32'(e.err));
          if (!e.wr) check("d_rdata", d_rdata, e.data);
        end
      end
    end
  end

  // One clock of stimulus; the reference predicts grants and pins and queues expected responses.
  task automatic cycle(input logic ireq, input logic [15:0] iad, input logic dreq,
                       input logic [3:0] we, input logic [15:0] dad, input logic [31:0] wd);
    logic        frc, pi, pd, mis;
    logic [15:0] exp_addr;
    logic [3:0]  exp_wen;
    d_exp_t      e;
    @(negedge clk);
    init_en = 1'b0;
    poke_en = 1'b0;
    i_req = ireq; i_addr = iad; d_req = dreq; d_we = we; d_addr = dad; d_wdata = wd;
    frc = GUARD && ireq && (ref_wait == MAX_WAIT);
    pd  = dreq && !frc;
    pi  = ireq && !pd;
    mis = (dad[1:0] != 2'b00);
    #1;
    check("i_rvalid", 32'(i_rvalid), 32'(last_pi));
    check("d_rvalid", 32'(d_rvalid), 32'(last_pd));
    check("i_gnt", 32'(i_gnt), 32'(pi));
    check("d_gnt", 32'(d_gnt), 32'(pd));
    exp_addr = pd ? dad : (pi ? iad : last_addr);
    exp_wen  = (pd && !mis) ? we : 4'h0;
    check("sram_addr", 32'(sram_addr), 32'(exp_addr));
    check("sram_w_en", 32'(sram_w_en), 32'(exp_wen));
    if (pd) begin
      e.wr = (we != 4'h0);
      e.err = mis;
      e.data = mis ? 32'h0 : ref_word(dad);
      dq.push_back(e);
      if (e.wr && !mis) begin
        for (int k = 0; k < 4; k++) if (we[k]) ref_mem[16'(dad + 16'(k))] = wd[8*k +: 8];
      end
    end
    if (pi) iq.push_back(ref_word(iad));
    last_addr = exp_addr;
    last_pi = pi;
    last_pd = pd;
    if (ireq && !pi) ref_wait = (ref_wait < 15) ? ref_wait + 1 : 15;
    else ref_wait = 0;
  endtask

  task automatic idle();
    cycle(1'b0, 16'h0, 1'b0, 4'h0, 16'h0, 32'h0);
  endtask

  // Backdoor write into both the SRAM model and the reference on an idle edge.
  task automatic poke(input logic [15:0] a, input logic [31:0] w);
    idle();
    poke_en = 1'b1; poke_addr = a; poke_word = w;
    for (int k = 0; k < 4; k++) ref_mem[16'(a + 16'(k))] = w[8*k +: 8];
  endtask

  logic        r_ir = 1'b0, r_dr = 1'b0;
  logic [15:0] r_ia = '0, r_da = '0;
  logic [3:0]  r_dwe = '0;
  logic [31:0] r_dwd = '0;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nmis;
    for (int a = 0; a < 65536; a++) ref_mem[a] = init_byte(16'(a));
    i_req = 1'b1; i_addr = 16'h0100; d_req = 1'b1; d_we = 4'hF; d_addr = 16'h0100;
    d_wdata = 32'hFFFF_FFFF;

    // Reset state with both requests asserted.
    @(negedge clk);
    init_en = 1'b0;
    #1;
    check("rst_i_gnt", 32'(i_gnt), 32'd0);
    check("rst_d_gnt", 32'(d_gnt), 32'd0);
    check("rst_i_rvalid", 32'(i_rvalid), 32'd0);
    check("rst_d_rvalid", 32'(d_rvalid), 32'd0);
    check("rst_d_err", 32'(d_err), 32'd0);
    check("rst_i_rdata", i_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    check("rst_sram_w_en", 32'(sram_w_en), 32'd0);
    check("rst_sram_addr", 32'(sram_addr), 32'd0);
    @(negedge clk);
    rst = 1'b0; i_req = 1'b0; d_req = 1'b0;

    // Fetch only.
    poke(16'h0010, 32'h1234_5678);
    cycle(1'b1, 16'h0010, 1'b0, 4'h0, 16'h0, 32'h0);
    check("fetch_only_gnt", 32'(i_gnt), 32'd1);
    idle();
    check("fetch_only_rdata", i_rdata, 32'h1234_5678);

    // Partial write then read-back next cycle.
    poke(16'h0020, 32'h1111_1111);
    cycle(1'b0, 16'h0, 1'b1, 4'b0011, 16'h0020, 32'hAABB_CCDD);
    cycle(1'b0, 16'h0, 1'b1, 4'b0000, 16'h0020, 32'h0);
    check("wr_resp_valid", 32'(d_rvalid), 32'd1);
    idle();
    check("rd_after_wr", d_rdata, 32'h1111_CCDD);

    // Contention: data first, fetch on the next cycle.
    poke(16'h0024, 32'hCAFE_F00D);
    cycle(1'b1, 16'h0030, 1'b1, 4'h0, 16'h0024, 32'h0);
    check("contend_d_gnt", 32'(d_gnt), 32'd1);
    check("contend_i_gnt", 32'(i_gnt), 32'd0);
    cycle(1'b1, 16'h0030, 1'b0, 4'h0, 16'h0, 32'h0);
    check("contend_i_next", 32'(i_gnt), 32'd1);

    // Misaligned store is suppressed and flagged.
    cycle(1'b0, 16'h0, 1'b1, 4'hF, 16'h0031, 32'hDEAD_BEEF);
    check("mis_w_en", 32'(sram_w_en), 32'd0);
    idle();
    check("mis_err", 32'(d_err), 32'd1);

    // Fetch across the top of the address space.
    poke(16'hFFFC, 32'h4433_2211);
    poke(16'h0000, 32'h8877_6655);
    cycle(1'b1, 16'hFFFD, 1'b0, 4'h0, 16'h0, 32'h0);
    idle();
    check("wrap_fetch", i_rdata, 32'h5544_3322);

    // Starvation: both held for 10 cycles.
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1, 16'(16'h0040 + 16'(4 * k)), 1'b1, 4'h0, 16'h0024, 32'h0);
      check("starve_i_gnt", 32'(i_gnt), 32'(GUARD && (k % 5 == 4)));
    end
    idle();

    // Reset mid-response drops the pending read and blocks a concurrent write.
    cycle(1'b0, 16'h0, 1'b1, 4'h0, 16'h0024, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    iq.delete();
    dq.delete();
    #1;
    check("rstmid_d_rvalid", 32'(d_rvalid), 32'd0);
    check("rstmid_d_rdata", d_rdata, 32'd0);
    @(negedge clk);
    i_req = 1'b1; i_addr = 16'h0050; d_req = 1'b1; d_we = 4'hF; d_addr = 16'h0040;
    d_wdata = 32'h0BAD_0BAD;
    #1;
    check("rstmid_d_gnt", 32'(d_gnt), 32'd0);
    check("rstmid_w_en", 32'(sram_w_en), 32'd0);
    @(negedge clk);
    rst = 1'b0; i_req = 1'b0; d_req = 1'b0;
    ref_wait = 0; last_addr = '0; last_pi = 1'b0; last_pd = 1'b0;
    cycle(1'b1, 16'h0030, 1'b1, 4'h0, 16'h0024, 32'h0);
    check("post_rst_d_gnt", 32'(d_gnt), 32'd1);

    // Randomized traffic with alternating light and saturating data phases.
    for (int n = 0; n < 400; n++) begin
      if (!r_ir || last_pi) begin
        r_ir = ($urandom_range(0, 3) != 0);
        r_ia = rand_addr();
      end
      if (!r_dr || last_pd) begin
        r_dr  = ((n / 50) % 2 == 1) || ($urandom_range(0, 2) != 0);
        r_dwe = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
        r_da  = rand_addr();
        r_dwd = $urandom;
      end
      cycle(r_ir, r_ia, r_dr, r_dwe, r_da, r_dwd);
    end
    idle();
    idle();

    check("i_queue_drained", 32'(iq.size()), 32'd0);
    check("d_queue_drained", 32'(dq.size()), 32'd0);
    nmis = 0;
    for (int a = 0; a < 65536; a++) if (mem[a] !== ref_mem[a]) nmis++;
    check("mem_image", 32'(nmis), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter that shares the single-ported byte-addressed 64 KiB SRAM between the instruction-fetch port and the load/store (data) port of the core. It issues one SRAM access per cycle, drives the SRAM `w_en`/`address`/`write_data` pins and returns registered read data with a one-cycle response pulse. It sits between the core's IF/MEM stages and the SRAM macro, and owns all SRAM pins.

## Interface
- `ADDR_W`, 16: SRAM byte-address width.
- `DATA_W`, 32: word width. Byte lanes are `DATA_W/8`.
- `MAX_WAIT`, 4: fetch starvation limit in cycles. Range 1..15. Used only with the guard enabled.

Ports:
- `clk` in 1: single clock; everything is on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `i_req` in 1: fetch request. Held with `i_addr` stable until `i_gnt`.
- `i_addr` in ADDR_W: fetch byte address.
- `i_gnt` out 1: fetch accepted this cycle.
- `i_rvalid` out 1: fetch response, one-cycle pulse.
- `i_rdata` out DATA_W: fetch read data. Valid only while `i_rvalid` is high.
- `d_req` in 1: data request. Held stable until `d_gnt`.
- `d_we` in 4: byte write strobes. 0 means a read.
- `d_addr` in ADDR_W: data byte address.
- `d_wdata` in DATA_W: store data, little-endian lanes.
- `d_gnt` out 1: data request accepted this cycle.
- `d_rvalid` out 1: data response pulse. It pulses for both reads and writes.
- `d_rdata` out DATA_W: load data.
- `d_err` out 1: misaligned-access flag. Valid with `d_rvalid`.
- `sram_w_en` out 4: SRAM byte write enables.
- `sram_addr` out ADDR_W: SRAM address.
- `sram_wdata` out DATA_W: SRAM write data.
- `sram_rdata` in DATA_W: SRAM combinational read data.

## Operation
- Grant logic is combinational from the requests and the registered state. At most one of `i_gnt`/`d_gnt` is high in a cycle.
- Default policy is fixed priority: data beats fetch.
  - `d_gnt = d_req & ~force_i`.
  - `i_gnt = i_req & (~d_req | force_i)`.
- SRAM pin mux:
  - On `d_gnt`: `sram_addr=d_addr`, `sram_wdata=d_wdata`, `sram_w_en = d_err_now ? 0 : d_we`.
  - On `i_gnt`: `sram_addr=i_addr`, `sram_w_en=0`.
  - Otherwise: `sram_addr` holds its last value and `sram_w_en=0`.
- Misalignment:
  - `d_err_now = d_gnt & (d_addr[1:0]!=0)`.
  - A misaligned write is suppressed: no SRAM byte changes.
  - A misaligned read returns 0.
  - `d_err` is registered with `d_rvalid`.
- Fetch alignment is the requester's responsibility. Fetch addresses are passed through unmodified.
- Response registers capture `sram_rdata` into `i_rdata`/`d_rdata` at the grant edge:
  - `i_rvalid <= i_gnt`.
  - `d_rvalid <= d_gnt`.
  - The rdata registers hold their value when not granted.
- Address arithmetic wraps modulo 2^ADDR_W. An access at 0xFFFD spans bytes 0xFFFD, 0xFFFE, 0xFFFF, 0x0000.

## Timing
- Grant is issued in the same cycle as the request (0-cycle arbitration).
- Response arrives exactly 1 cycle after the grant.
- Throughput is 1 access per cycle overall.
- Write ordering: a write commits at the grant edge. A read of the same address granted in the next cycle returns the new data.
- Simultaneous requests: data is granted and fetch waits, subject to the starvation guard.
- Back-to-back data requests may starve fetch when the guard is compiled out.
- Reset values: `i_gnt=d_gnt=0` (both requests are masked while `rst` is high), `i_rvalid=d_rvalid=d_err=0`, `i_rdata=d_rdata=0`, `sram_w_en=0`, `sram_addr=0`, wait counter 0.
- Reset asserted mid-operation: a pending response is dropped. A write granted in the same cycle that `rst` rises is not performed.

## Configuration
- `SRAM_ARB_STARVE_GUARD_EN` defined: a saturating counter `wait_cnt` (4 bits) is present.
  - Increments when `i_req & ~i_gnt`.
  - Clears when `i_gnt | ~i_req`.
  - `force_i = i_req & (wait_cnt == MAX_WAIT)`.
  - Fetch therefore waits at most `MAX_WAIT` cycles under continuous data traffic.
- `SRAM_ARB_STARVE_GUARD_EN` undefined: `force_i=0`, there is no counter, and the policy is pure data-first priority.

## Structure
- Shared package `sram_pkg` holds:
  - `SRAM_ADDR_W`, `SRAM_DATA_W`.
  - The lane-count constant.
  - The `port_sel_e` enum `{SEL_NONE, SEL_I, SEL_D}` used by the mux and the testbench.
- Sub-module `sram_arb_grant` holds the combinational priority and guard decision (`i_req`, `d_req`, `wait_cnt` → `port_sel`).
- The top level holds the counter, the mux and the response registers.

## Test plan
- Fetch only: `i_req=1`, `i_addr=0x0010`, SRAM word 0x12345678. Expect `i_gnt` that cycle, then `i_rvalid=1` and `i_rdata=0x12345678` the next cycle.
- Write then read:
  - Cycle n: `d_we=4'b0011`, `d_addr=0x0020`, `d_wdata=0xAABBCCDD` over old word 0x11111111. Expect `d_rvalid` at n+1.
  - Cycle n+1: read 0x0020. Expect `d_rdata=0x1111CCDD`.
- Contention: `i_req` and `d_req` both high for 1 cycle. Expect `d_gnt=1`, `i_gnt=0`, then `i_gnt=1` the following cycle.
- Starvation guard (macro on, `MAX_WAIT=4`): `d_req` and `i_req` held high for 10 cycles.
  - Expect `i_gnt` on cycle 5, with `d_gnt=0` on that cycle.
  - Expect the pattern to repeat every 5 cycles.
  - Macro off: `i_gnt` never rises.
- Misaligned: `d_we=4'hF`, `d_addr=0x0031`. Expect `sram_w_en=0`, `d_rvalid=1`, `d_err=1`, and memory unchanged.
- Reset mid-access: `rst` pulsed in the cycle after a `d_gnt` read. Expect `d_rvalid` forced low and `d_rdata=0`; the grant rules above are unchanged after reset is released.
